if_prefetch: RTL and testbench

//  Instruction-fetch stage that feeds the single-cycle core's decode/execute datapath.

---
 rtl/if_prefetch_pkg.sv | 14 +
 rtl/if_queue.sv | 61 ++++++
 rtl/if_prefetch.sv | 99 +++++++++
 tb/tb_if_prefetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared fetch-stage definitions: datapath width, reset PC and
// the {pc, inst} entry carried through the fetch queue.
package if_prefetch_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0;
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; pointers wrap at
// DEPTH so non-power-of-two depths work. Flush clears everything.
module if_queue
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output fq_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic w_pop;
    logic w_push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CW'(DEPTH));
    assign count = r_cnt;
    assign head  = r_mem[r_rd];

    // a pop frees the slot a same-cycle push lands in when full
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) begin
                r_rd <= nxt(r_rd);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: credit-limited word fetch from a shared
// memory port, in-order queueing, valid/ready delivery, redirect flush.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int          CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ipc;
    logic            r_inflight;
    logic            r_kill;

    logic            w_pop;
    logic            w_push;
    logic            w_grant;
    logic [CW:0]     w_occ;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    fq_entry_t       w_head;
    fq_entry_t       w_push_data;

    assign w_pop = inst_valid & inst_ready;

    // queued + in flight - leaving this cycle must leave a free slot
    assign w_occ = {1'b0, w_count}
                 + (CW + 1)'(r_inflight)
                 - (CW + 1)'(w_pop);

    assign imem_req  = ~rst & ~redirect & (w_occ < QD);
    assign imem_addr = r_pc[ADDR_W-1:0];
    assign w_grant   = imem_req & imem_gnt;

    assign w_push      = r_inflight & ~r_kill & ~redirect & ~rst;
    assign w_push_data = '{pc: r_ipc, inst: imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ipc      <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_grant;
            r_kill     <= redirect & w_grant;
            if (redirect) begin
                r_pc <= redirect_pc & ~(XLEN'(3));
            end else if (w_grant) begin
                r_pc  <= r_pc + XLEN'(4);
                r_ipc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && w_full && !w_pop))
                else $error("if_prefetch: push into full queue");
        end
    end

    if_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign inst_valid = ~rst & ~w_empty;
    assign inst       = inst_valid ? w_head.inst : '0;
    assign inst_pc    = inst_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Fetch-stage bench: directed table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int ADDR_W = 7;
    localparam int QDEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [XLEN-1:0]   inst_pc;
    logic              inst_ready;

    always #5 clk = ~clk;

    if_prefetch #(
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    typedef struct {
        bit          r;
        bit          g;
        bit          d;
        bit          rdy;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [11];

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q [$];
    logic [31:0] m_pend [$];
    bit          m_pop;
    bit          e_req;

    bit              mem_due;
    logic [ADDR_W-1:0] mem_addr;

    function automatic logic [31:0] memfn(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 ^ ({25'b0, a} * 32'h0101_0101);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // apply one cycle of inputs and check against the reference model
    task automatic drive(input bit r, input bit g, input bit d,
                         input bit rdy, input logic [31:0] p);
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einst;
        @(negedge clk);
        rst         = r;
        imem_gnt    = g;
        redirect    = d;
        redirect_pc = p;
        inst_ready  = rdy;
        imem_rdata  = mem_due ? memfn(mem_addr) : $urandom;
        #1;
        m_pop = !r && (m_q.size() > 0) && rdy;
        e_req = !r && !d &&
                (m_q.size() + m_pend.size() - (m_pop ? 1 : 0) < QDEPTH);
        ev    = !r && (m_q.size() > 0);
        epc   = ev ? m_q[0] : 32'h0;
        einst = ev ? memfn(epc[ADDR_W-1:0]) : 32'h0;
        chk("req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("addr", {25'b0, imem_addr}, {25'b0, m_pc[ADDR_W-1:0]});
        chk("valid", {31'b0, inst_valid}, {31'b0, ev});
        chk("inst_pc", inst_pc, epc);
        chk("inst", inst, einst);
    endtask

    task automatic commit();
        bit          has;
        logic [31:0] rp;
        mem_due  = imem_req & imem_gnt;
        mem_addr = imem_addr;
        if (rst) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_pend.delete();
        end else begin
            has = m_pend.size() > 0;
            rp  = has ? m_pend.pop_front() : 32'h0;
            if (m_pop) void'(m_q.pop_front());
            if (redirect) begin
                m_q.delete();
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (has) m_q.push_back(rp);
                if (e_req && imem_gnt) begin
                    m_pend.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit g, input bit d,
                        input bit rdy, input logic [31:0] p);
        drive(r, g, d, rdy, p);
        commit();
    endtask

    function automatic vec_t mk(bit r, bit g, bit d, bit rdy,
                                logic [31:0] rpc, bit rq,
                                logic [31:0] a, bit v, logic [31:0] pc);
        vec_t x;
        x = '{r, g, d, rdy, rpc, rq, a, v, pc};
        return x;
    endfunction

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; redirect = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0; imem_rdata = '0;
        mem_due = 1'b0; mem_addr = '0; m_pc = 32'h0;

        // reset, fill latency, stream, redirect while 0x08 is in flight
        tbl[0]  = mk(1, 1, 0, 1, 0,     0, 0,     0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0,     0, 0,     0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 0,     1, 0,     0, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0,     1, 4,     0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0,     1, 8,     1, 0);
        tbl[5]  = mk(0, 1, 1, 1, 'h42,  0, 0,     1, 4);
        tbl[6]  = mk(0, 1, 0, 1, 0,     1, 'h40,  0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0,     1, 'h44,  0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0,     1, 'h48,  1, 'h40);
        tbl[9]  = mk(0, 1, 0, 1, 0,     1, 'h4c,  1, 'h44);
        tbl[10] = mk(0, 1, 0, 1, 0,     1, 'h50,  1, 'h48);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].d, tbl[i].rdy, tbl[i].rpc);
            chk("t_req", {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk("t_addr", {25'b0, imem_addr}, tbl[i].e_addr);
            chk("t_valid", {31'b0, inst_valid}, {31'b0, tbl[i].e_valid});
            chk("t_pc", inst_pc, tbl[i].e_pc);
            commit();
        end

        // backpressure: credits run out, req drops, nothing lost
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 0);
            if (i == 5) begin
                chk("bp_req", {31'b0, imem_req}, 32'h0);
                chk("bp_valid", {31'b0, inst_valid}, 32'h1);
            end
            commit();
        end
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0);

        // grant denial with request pending
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);

        // reset with entries queued and a response in flight
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        chk("rst_addr", {25'b0, imem_addr}, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        commit();
        drive(0, 1, 0, 1, 0);
        chk("rst_drop", {31'b0, inst_valid}, 32'h0);
        commit();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 9) < 6,
                 $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
